// File: rtl/posit_extract_pipe_if.sv
// Posit datapath types and the handshake bundle for the decoder pipe.
// The package sits here because the interface itself carries the decoded
// value type on its output side.
package posit_pkg;
   localparam int NBITS = 32;
   localparam int ES    = 3;
   localparam int FBITS = 26;
   localparam int SBITS = 9;

   typedef struct packed {
      logic                    sign;
      logic signed [SBITS-1:0] scale;
      logic [ES-1:0]           exponent;
      logic [FBITS-1:0]        fraction;
      logic                    inf;
      logic                    zero;
   } value;
endpackage

// Input and output valid/ready channels of the decoder.
// slave is the decoder side, master is the producer/consumer side.
interface posit_extract_pipe_if #(
   parameter int TAG_BITS = 8
);
   import posit_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [NBITS-1:0]    in_data;
   logic [TAG_BITS-1:0] in_tag;
   logic                out_valid;
   logic                out_ready;
   value                out_value;
   logic [TAG_BITS-1:0] out_tag;

   modport slave (
      input  in_valid, in_data, in_tag, out_ready,
      output in_ready, out_valid, out_value, out_tag
   );

   modport master (
      output in_valid, in_data, in_tag, out_ready,
      input  in_ready, out_valid, out_value, out_tag
   );
endinterface

// File: rtl/posit_extract_pipe.sv
// Three-stage elastic posit<32,3> decoder: sign/abs, regime, assemble.
// Each stage holds one word; the ready chain runs combinationally from
// out_ready back to in_ready, so a full pipe still streams one word/cycle.
module posit_extract_pipe
   import posit_pkg::*;
#(
   parameter int TAG_BITS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   posit_extract_pipe_if.slave   bus
);

   logic vld_p0, vld_p1, vld_p2;
   logic ld_p0, ld_p1, ld_p2;

   // stage p0: sign, magnitude, special-case flags
   logic                sign_p0, zero_p0, inf_p0;
   logic [NBITS-2:0]    mag_p0;
   logic [TAG_BITS-1:0] tag_p0;

   // stage p1: regime decoded, leftover bits left-aligned
   logic                sign_p1, zero_p1, inf_p1;
   logic signed [5:0]   k_p1;
   logic [ES+FBITS-1:0] rem_p1;
   logic [TAG_BITS-1:0] tag_p1;

   // stage p2: assembled value presented downstream
   value                val_p2;
   logic [TAG_BITS-1:0] tag_p2;

   // A stage may load when empty or when its current word moves on.
   assign ld_p2 = !vld_p2 || bus.out_ready;
   assign ld_p1 = !vld_p1 || ld_p2;
   assign ld_p0 = !vld_p0 || ld_p1;

   assign bus.in_ready  = ld_p0;
   assign bus.out_valid = vld_p2;
   assign bus.out_value = val_p2;
   assign bus.out_tag   = tag_p2;

   // Low 31 bits of the two's complement; NaR wraps to zero and is flagged.
   logic [NBITS-2:0] abs_s1;
   assign abs_s1 = bus.in_data[NBITS-1] ? (~bus.in_data[NBITS-2:0] + 31'd1)
                                        : bus.in_data[NBITS-2:0];

   // Stage valid bits; reset drops every word in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         if (ld_p0) vld_p0 <= bus.in_valid;
         if (ld_p1) vld_p1 <= vld_p0;
         if (ld_p2) vld_p2 <= vld_p1;
      end
   end

   // Capture the incoming word when stage p0 accepts it.
   always_ff @(posedge clk) begin
      if (ld_p0 && bus.in_valid) begin
         sign_p0 <= bus.in_data[NBITS-1];
         mag_p0  <= abs_s1;
         zero_p0 <= (bus.in_data == 32'h0000_0000);
         inf_p0  <= (bus.in_data == 32'h8000_0000);
         tag_p0  <= bus.in_tag;
      end
   end

   // Regime run length: identical bits from bit 30 down, 1..31.
   logic       reg_bit_s2, run_done_s2;
   logic [4:0] run_s2;
   logic [5:0] run6_s2;
   logic signed [5:0]   k_s2;
   logic [ES+FBITS-1:0] rem_s2;
   always_comb begin
      reg_bit_s2  = mag_p0[NBITS-2];
      run_s2      = 5'd0;
      run_done_s2 = 1'b0;
      for (int i = NBITS - 2; i >= 0; i--) begin
         if (!run_done_s2) begin
            if (mag_p0[i] == reg_bit_s2) run_s2 = run_s2 + 5'd1;
            else                         run_done_s2 = 1'b1;
         end
      end
      run6_s2 = {1'b0, run_s2};
      k_s2    = reg_bit_s2 ? $signed(run6_s2 - 6'd1) : $signed(6'd0 - run6_s2);
      // Dropping run+1 regime bits from bit 30 leaves bits [28:0] shifted by run-1.
      rem_s2  = mag_p0[ES+FBITS-1:0] << (run_s2 - 5'd1);
   end

   // Advance the regime result into stage p1.
   always_ff @(posedge clk) begin
      if (ld_p1 && vld_p0) begin
         sign_p1 <= sign_p0;
         zero_p1 <= zero_p0;
         inf_p1  <= inf_p0;
         k_p1    <= k_s2;
         rem_p1  <= rem_s2;
         tag_p1  <= tag_p0;
      end
   end

   // Assemble the value; specials override every other field.
   value val_s3;
   always_comb begin
      val_s3 = '0;
      if (zero_p1) begin
         val_s3.zero = 1'b1;
      end else if (inf_p1) begin
         val_s3.inf  = 1'b1;
         val_s3.sign = 1'b1;
      end else begin
         val_s3.sign     = sign_p1;
         val_s3.exponent = rem_p1[ES+FBITS-1:FBITS];
         val_s3.fraction = rem_p1[FBITS-1:0];
         // k*8 + exponent is just the concatenation since exponent < 8.
         val_s3.scale    = $signed({k_p1, rem_p1[ES+FBITS-1:FBITS]});
      end
   end

   // Output register; cleared by reset so the port reads all-zero afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         val_p2 <= '0;
         tag_p2 <= '0;
      end else if (ld_p2 && vld_p1) begin
         val_p2 <= val_s3;
         tag_p2 <= tag_p1;
      end
   end

endmodule

// File: tb/tb_posit_extract_pipe.sv
// Bench for posit_extract_pipe: directed table, backpressure, random
// streaming against a reference decode, and reset in mid-stream.
module tb_posit_extract_pipe;
   import posit_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   posit_extract_pipe_if #(.TAG_BITS(8)) bus ();
   posit_extract_pipe #(.TAG_BITS(8)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  tag;
      value        exp;
   } vec_t;

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  tag;
   } sb_t;

   sb_t        sb_q[$];
   logic [7:0] tag_ctr = 8'd0;
   int         snt = 0;
   int         rcv = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
      end
   endtask

   function automatic value mk(input logic s, input int sc, input logic [2:0] e,
                               input logic [25:0] f, input logic inf, input logic z);
      value v;
      v.sign = s; v.scale = 9'(sc); v.exponent = e; v.fraction = f;
      v.inf = inf; v.zero = z;
      return v;
   endfunction

   // Reference decode on a 64-bit window: regime at the top, shift it out.
   function automatic value ref_decode(input logic [31:0] w);
      value        v;
      logic [31:0] m;
      logic [63:0] t;
      int          run, k;
      logic        r;
      v = '0;
      if (w == 32'h0) begin v.zero = 1'b1; return v; end
      if (w == 32'h8000_0000) begin v.inf = 1'b1; v.sign = 1'b1; return v; end
      v.sign = w[31];
      m = w[31] ? (~w + 32'd1) : w;
      t = {m[30:0], 33'b0};
      r = t[63];
      run = 0;
      while (run < 31 && t[63-run] == r) run++;
      k = r ? run - 1 : -run;
      t = t << (run + 1);
      v.exponent = t[63:61];
      v.fraction = t[60:35];
      v.scale    = 9'(k * 8 + int'(t[63:61]));
      return v;
   endfunction

   function automatic logic [31:0] rand_word();
      case ($urandom % 8)
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'($urandom % 64);
         3:       return 32'hFFFF_FFFF - 32'($urandom % 64);
         default: return $urandom;
      endcase
   endfunction

   // Send one word into an empty pipe and check when and what comes out.
   task automatic apply_vec(input vec_t v);
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = v.data; bus.in_tag = v.tag; bus.out_ready = 1'b1;
      #1 chk("vec_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("vec_early_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      chk("vec_valid", 64'(bus.out_valid), 64'd1);
      chk("vec_value", 64'(bus.out_value), 64'(v.exp));
      chk("vec_tag", 64'(bus.out_tag), 64'(v.tag));
   endtask

   // One cycle of streaming with scoreboard bookkeeping.
   task automatic step(input logic iv, input logic ordy, output logic got);
      logic [31:0] w;
      sb_t         e;
      @(negedge clk);
      w = rand_word();
      bus.in_valid = iv; bus.in_data = w; bus.in_tag = tag_ctr; bus.out_ready = ordy;
      #1;
      got = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
         got = 1'b1;
         rcv++;
         if (sb_q.size() == 0) begin
            chk("stream_unexpected", 64'(bus.out_tag), 64'hFFFF);
         end else begin
            e = sb_q.pop_front();
            chk("stream_value", 64'(bus.out_value), 64'(ref_decode(e.data)));
            chk("stream_tag", 64'(bus.out_tag), 64'(e.tag));
         end
      end
      if (iv && bus.in_ready) begin
         sb_q.push_back({w, tag_ctr});
         tag_ctr++;
         snt++;
      end
   endtask

   vec_t        vt[10];
   logic [31:0] bp[5];
   value        held_v;
   logic [7:0]  held_t;
   int          sent, recv, stale, bubbles, guard;
   logic        g, first;

   initial begin
      vt[0] = '{32'h0000_0000, 8'h10, mk(0, 0, 0, 0, 0, 1)};
      vt[1] = '{32'h8000_0000, 8'h11, mk(1, 0, 0, 0, 1, 0)};
      vt[2] = '{32'h4000_0000, 8'h12, mk(0, 0, 0, 0, 0, 0)};
      vt[3] = '{32'h4800_0000, 8'h13, mk(0, 2, 2, 0, 0, 0)};
      vt[4] = '{32'hC000_0000, 8'h14, mk(1, 0, 0, 0, 0, 0)};
      vt[5] = '{32'h7FFF_FFFF, 8'h15, mk(0, 240, 0, 0, 0, 0)};
      vt[6] = '{32'h0000_0001, 8'h16, mk(0, -240, 0, 0, 0, 0)};
      vt[7] = '{32'h4000_0001, 8'h17, mk(0, 0, 0, 26'h1, 0, 0)};
      vt[8] = '{32'h3000_0000, 8'h18, mk(0, -4, 4, 0, 0, 0)};
      vt[9] = '{32'hFFFF_FFFF, 8'h19, mk(1, -240, 0, 0, 0, 0)};
      bp = '{32'h4800_0000, 32'hC000_0000, 32'h4000_0001, 32'h7FFF_FFFF, 32'h3000_0000};

      // reset state
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
      #12;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_value", 64'(bus.out_value), 64'd0);
      chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // directed table
      for (int i = 0; i < 10; i++) apply_vec(vt[i]);

      // backpressure: only three words fit while the output is stalled
      @(negedge clk);
      bus.out_ready = 1'b0;
      sent = 0;
      for (int s = 0; s < 8; s++) begin
         @(negedge clk);
         bus.in_valid = (sent < 5);
         bus.in_data  = bp[sent];
         bus.in_tag   = 8'(sent + 1);
         #1;
         if (bus.in_valid && bus.in_ready) sent++;
         if (s == 6) begin held_v = bus.out_value; held_t = bus.out_tag; end
      end
      chk("bp_accepted", 64'(sent), 64'd3);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_hold_value", 64'(bus.out_value), 64'(held_v));
      chk("bp_hold_tag", 64'(bus.out_tag), 64'(held_t));
      chk("bp_head_tag", 64'(bus.out_tag), 64'd1);
      recv = 0;
      for (int s = 0; s < 40 && recv < 5; s++) begin
         @(negedge clk);
         bus.out_ready = 1'b1;
         bus.in_valid  = (sent < 5);
         bus.in_data   = (sent < 5) ? bp[sent] : 32'h0;
         bus.in_tag    = 8'(sent + 1);
         #1;
         if (bus.out_valid) begin
            chk("bp_out_tag", 64'(bus.out_tag), 64'(recv + 1));
            chk("bp_out_value", 64'(bus.out_value), 64'(ref_decode(bp[recv])));
            recv++;
         end
         if (bus.in_valid && bus.in_ready) sent++;
      end
      chk("bp_received", 64'(recv), 64'd5);
      chk("bp_sent", 64'(sent), 64'd5);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("bp_no_duplicate", 64'(bus.out_valid), 64'd0);

      // random streaming with random backpressure
      snt = 0; rcv = 0; guard = 0;
      while (snt < 1000 && guard < 8000) begin
         step(($urandom % 4) != 0, ($urandom % 3) != 0, g);
         guard++;
      end
      guard = 0;
      while (rcv < snt && guard < 50) begin step(1'b0, 1'b1, g); guard++; end
      chk("stream_sent", 64'(snt), 64'd1000);
      chk("stream_received", 64'(rcv), 64'd1000);

      // continuous ready: one result per cycle once the pipe is primed
      first = 1'b0; bubbles = 0;
      for (int s = 0; s < 30; s++) begin
         step(1'b1, 1'b1, g);
         if (g) first = 1'b1;
         else if (first) bubbles++;
      end
      chk("full_rate_started", 64'(first), 64'd1);
      chk("full_rate_bubbles", 64'(bubbles), 64'd0);
      guard = 0;
      while (rcv < snt && guard < 50) begin step(1'b0, 1'b1, g); guard++; end
      chk("full_rate_drained", 64'(rcv), 64'(snt));

      // reset with three words in flight
      sent = 0;
      for (int s = 0; s < 6; s++) begin
         @(negedge clk);
         bus.out_ready = 1'b0;
         bus.in_valid  = (sent < 3);
         bus.in_data   = 32'h4800_0000;
         bus.in_tag    = 8'(8'h40 + sent);
         #1;
         if (bus.in_valid && bus.in_ready) sent++;
      end
      bus.in_valid = 1'b0;
      chk("mid_full", 64'(bus.out_valid), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("mid_async_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_async_value", 64'(bus.out_value), 64'd0);
      chk("mid_async_tag", 64'(bus.out_tag), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      bus.out_ready = 1'b1;
      stale = 0;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         if (bus.out_valid) stale++;
      end
      chk("mid_no_stale", 64'(stale), 64'd0);
      apply_vec('{32'h4800_0000, 8'h77, mk(0, 2, 2, 0, 0, 0)});

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
